// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types and defaults for the clkdiv_sched run-time
// controller and its modulus counter.
package clkdiv_pkg;

   // Controller states: stopped, running, finishing the last high phase.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int CLKDIV_WIDTH_DEF = 8;
   localparam int CLKDIV_DIV_DEF   = 3;

endpackage

// File: rtl/clkdiv_cnt.sv
// clkdiv_cnt: modulus-D phase counter. Counts 0..div-1 while run is high,
// raises wrap on the last count of a phase and clears back to 0 on demand.
module clkdiv_cnt
   import clkdiv_pkg::*;
#(
   parameter int WIDTH = CLKDIV_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             run,
   input  logic [WIDTH-1:0] div,
   output logic             wrap,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] div_m1;

   // div is never zero here, so div-1 in WIDTH bits is the last count of a phase.
   assign div_m1 = div - WIDTH'(1);
   assign wrap   = run && (cnt_q == div_m1);
   assign cnt    = cnt_q;

   // Phase counter: clear wins, otherwise count and fold back to 0 on wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (run) begin
         cnt_q <= wrap ? '0 : cnt_q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/clkdiv_sched.sv
// clkdiv_sched: run-time controller for the mod-N clock divider.
// Starts/stops clk_div only in its low phase and commits new divisors only
// at a 1->0 boundary, so no runt pulse is ever produced.
// Optional build macro CLKDIV_SCHED_ZERO_ERR_EN: a zero divisor is accepted,
// dropped and flagged on cfg_err; without it a zero divisor is clamped to 1.
module clkdiv_sched
   import clkdiv_pkg::*;
#(
   parameter int WIDTH       = CLKDIV_WIDTH_DEF,
   parameter int DEFAULT_DIV = CLKDIV_DIV_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             clk_div,
   output logic             tick,
`ifdef CLKDIV_SCHED_ZERO_ERR_EN
   output logic             cfg_err,
`endif
   output logic             busy
);

   state_t           state_reg;
   state_t           state_next;
   logic             en_q;
   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] pend_div_q;
   logic             pend_q;
   logic             clk_div_q;
   logic             tick_q;
   logic             run;
   logic             stop_now;
   logic             wrap;
   logic             fall;
   logic             accept;
   logic             div_zero;
   logic [WIDTH-1:0] cnt;
`ifdef CLKDIV_SCHED_ZERO_ERR_EN
   logic             cfg_err_q;
`else
   logic [WIDTH-1:0] acc_div;
`endif

   // Stopping from the low phase halts immediately, so the counter must not
   // advance (and clk_div must not rise) on that edge.
   assign stop_now = (state_reg == RUN) && !en_q && !clk_div_q;
   assign run      = (state_reg != IDLE) && !stop_now;
   assign fall     = wrap && clk_div_q;
   assign accept   = cfg_valid && cfg_ready;
   assign div_zero = (cfg_div == '0);
`ifndef CLKDIV_SCHED_ZERO_ERR_EN
   assign acc_div  = div_zero ? WIDTH'(1) : cfg_div;
`endif

   clkdiv_cnt #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (!run),
      .run   (run),
      .div   (div_q),
      .wrap  (wrap),
      .cnt   (cnt)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next state: leave RUN/DRAIN only through the low phase or its 1->0 edge.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (en_q) state_next = RUN;
         end
         RUN: begin
            if (!en_q) state_next = (!clk_div_q || fall) ? IDLE : DRAIN;
         end
         DRAIN: begin
            if (en_q)      state_next = RUN;
            else if (fall) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Status outputs decoded from state and the pending flag.
   always_comb begin
      busy      = (state_reg != IDLE);
      cfg_ready = !pend_q;
   end

   // Run request register and divided-clock output stage; tick marks each toggle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q      <= 1'b0;
         clk_div_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         en_q   <= en;
         tick_q <= wrap;
         if (wrap) clk_div_q <= !clk_div_q;
      end
   end

   // Divisor handshake: direct load when idle, otherwise queue until the next fall.
   // Accept and commit never coincide because accept needs pend_q low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q      <= WIDTH'(DEFAULT_DIV);
         pend_div_q <= '0;
         pend_q     <= 1'b0;
`ifdef CLKDIV_SCHED_ZERO_ERR_EN
         cfg_err_q  <= 1'b0;
`endif
      end else begin
         if (fall && pend_q) begin
            div_q  <= pend_div_q;
            pend_q <= 1'b0;
         end
`ifdef CLKDIV_SCHED_ZERO_ERR_EN
         cfg_err_q <= accept && div_zero;
         if (accept && !div_zero) begin
            if (state_reg == IDLE) begin
               div_q <= cfg_div;
            end else begin
               pend_div_q <= cfg_div;
               pend_q     <= 1'b1;
            end
         end
`else
         if (accept) begin
            if (state_reg == IDLE) begin
               div_q <= acc_div;
            end else begin
               pend_div_q <= acc_div;
               pend_q     <= 1'b1;
            end
         end
`endif
      end
   end

   assign clk_div = clk_div_q;
   assign tick    = tick_q;
`ifdef CLKDIV_SCHED_ZERO_ERR_EN
   assign cfg_err = cfg_err_q;
`endif

endmodule

// File: tb/tb_clkdiv_sched.sv
// tb_clkdiv_sched: scoreboard bench for clkdiv_sched. The stimulus process
// drives inputs on the falling edge and pushes the expected post-edge outputs
// from a phase-countdown reference model; the monitor pops and compares
// shortly after every rising edge.
module tb_clkdiv_sched;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         cfg_valid = 1'b0;
   logic [W-1:0] cfg_div = '0;
   logic         cfg_ready;
   logic         clk_div;
   logic         tick;
   logic         busy;
`ifdef CLKDIV_SCHED_ZERO_ERR_EN
   logic         cfg_err;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic clk_div;
      logic tick;
      logic busy;
      logic cfg_ready;
      logic cfg_err;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: level, cycles left in the current phase, active divisor,
   // queued update, delayed run request.
   bit m_active;
   bit m_lvl;
   bit m_en_d;
   int m_left;
   int m_div;
   int m_pend[$];

   clkdiv_sched #(.WIDTH(W), .DEFAULT_DIV(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .clk_div   (clk_div),
      .tick      (tick),
`ifdef CLKDIV_SCHED_ZERO_ERR_EN
      .cfg_err   (cfg_err),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_active = 1'b0;
      m_lvl    = 1'b0;
      m_en_d   = 1'b0;
      m_left   = 0;
      m_div    = 3;
      m_pend.delete();
      exp_q.delete();
   endtask

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   // One clock: drive inputs, advance the model over the coming rising edge,
   // and queue the outputs that edge must produce.
   task automatic cycle(input bit e, input bit v, input int d);
      bit   acc;
      bit   was_active;
      bit   falling;
      bit   tick_e;
      bit   err_e;
      int   dv;
      exp_t x;
      @(negedge clk);
      en        = e;
      cfg_valid = v;
      cfg_div   = W'(d);
      acc        = v && (m_pend.size() == 0);
      was_active = m_active;
      falling    = 1'b0;
      tick_e     = 1'b0;
      err_e      = 1'b0;
      dv         = d;
      if (acc) $display("cfg accept d=%0d while %s", d, was_active ? "running" : "idle");
      if (acc && dv == 0) begin
`ifdef CLKDIV_SCHED_ZERO_ERR_EN
         err_e = 1'b1;
         acc   = 1'b0;
`else
         dv = 1;
`endif
      end
      if (acc && !was_active) m_div = dv;
      if (!was_active) begin
         m_lvl = 1'b0;
         if (m_en_d) begin
            m_active = 1'b1;
            m_left   = m_div;
         end
      end else if (!m_en_d && !m_lvl) begin
         m_active = 1'b0;
      end else begin
         if (m_left == 1) begin
            tick_e  = 1'b1;
            falling = m_lvl;
            m_lvl   = !m_lvl;
            if (falling && m_pend.size() > 0) m_div = m_pend.pop_front();
            m_left = m_div;
         end else begin
            m_left--;
         end
         if (!m_en_d && falling) m_active = 1'b0;
      end
      if (acc && was_active) m_pend.push_back(dv);
      m_en_d = e;
      x.clk_div   = m_lvl;
      x.tick      = tick_e;
      x.busy      = m_active;
      x.cfg_ready = (m_pend.size() == 0);
      x.cfg_err   = err_e;
      exp_q.push_back(x);
   endtask

   task automatic run_n(input int n, input bit e);
      for (int i = 0; i < n; i++) cycle(e, 1'b0, 0);
   endtask

   // Advance until the model sits in the wanted phase position (bounded).
   task automatic wait_phase(input bit want_lvl, input int want_left, input bit e);
      int n = 0;
      while (!(m_active && m_lvl == want_lvl && (want_left < 0 || m_left == want_left))
             && n < 300) begin
         cycle(e, 1'b0, 0);
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL phase_wait: got no match after %0d cycles, required a match", n);
      end
   endtask

   // Offer a divisor once the model says the slot is free.
   task automatic offer(input int d, input bit e);
      int n = 0;
      while (m_pend.size() != 0 && n < 300) begin
         cycle(e, 1'b0, 0);
         n++;
      end
      cycle(e, 1'b1, d);
   endtask

   task automatic do_reset_release();
      @(negedge clk);
      en        = 1'b0;
      cfg_valid = 1'b0;
      rst       = 1'b0;
      model_reset();
   endtask

   // Monitor: compare DUT outputs with the queued expectation after each edge.
   initial begin
      exp_t e;
      exp_t got;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e             = exp_q.pop_front();
            got.clk_div   = clk_div;
            got.tick      = tick;
            got.busy      = busy;
            got.cfg_ready = cfg_ready;
`ifdef CLKDIV_SCHED_ZERO_ERR_EN
            got.cfg_err   = cfg_err;
`else
            got.cfg_err   = 1'b0;
`endif
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL outputs t=%0t: got clk_div/tick/busy/cfg_ready/cfg_err=%b%b%b%b%b, required %b%b%b%b%b",
                        $time, got.clk_div, got.tick, got.busy, got.cfg_ready, got.cfg_err,
                        e.clk_div, e.tick, e.busy, e.cfg_ready, e.cfg_err);
            end
         end
      end
   end

   initial begin
      logic [10:0] gold_clk;
      logic [10:0] gold_tick;
      gold_clk  = 11'b100_0111_0000;
      gold_tick = 11'b100_1001_0000;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_clk_div", int'(clk_div), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_cfg_ready", int'(cfg_ready), 1);
      do_reset_release();

      // Start at the default divisor: rises at 4 and 10, falls at 7.
      for (int i = 0; i <= 10; i++) begin
         cycle(1'b1, 1'b0, 0);
         @(posedge clk);
         #3;
         chk($sformatf("start_clk_div_e%0d", i), int'(clk_div), int'(gold_clk[i]));
         chk($sformatf("start_tick_e%0d", i), int'(tick), int'(gold_tick[i]));
         chk($sformatf("start_busy_e%0d", i), int'(busy), (i >= 1) ? 1 : 0);
      end

      // Update to 5 during a high phase; commits at the next fall.
      wait_phase(1'b1, -1, 1'b1);
      offer(5, 1'b1);
      run_n(30, 1'b1);

      // D=4, drop en one cycle into the high phase, then drain.
      offer(4, 1'b1);
      for (int n = 0; n < 100 && m_div != 4; n++) cycle(1'b1, 1'b0, 0);
      wait_phase(1'b1, 3, 1'b1);
      run_n(12, 1'b0);
      // Re-raise en while draining: no phase restart.
      run_n(3, 1'b1);
      wait_phase(1'b1, 4, 1'b1);
      run_n(2, 1'b0);
      run_n(15, 1'b1);

      // Zero divisor.
      offer(0, 1'b1);
      run_n(14, 1'b1);

      // Stop, load 6 while idle, restart.
      for (int n = 0; n < 100 && m_active; n++) cycle(1'b0, 1'b0, 0);
      run_n(2, 1'b0);
      offer(6, 1'b0);
      run_n(2, 1'b0);
      run_n(24, 1'b1);

      // Asynchronous reset mid-high-phase with an update pending.
      wait_phase(1'b1, 6, 1'b1);
      offer(5, 1'b1);
      @(posedge clk);
      #4;
      chk("pre_reset_clk_div", int'(clk_div), 1);
      chk("pre_reset_cfg_ready", int'(cfg_ready), 0);
      rst = 1'b1;
      #1;
      chk("async_reset_clk_div", int'(clk_div), 0);
      chk("async_reset_busy", int'(busy), 0);
      chk("async_reset_tick", int'(tick), 0);
      chk("async_reset_cfg_ready", int'(cfg_ready), 1);
      do_reset_release();
      run_n(25, 1'b1);

      // Randomized run requests and divisor offers.
      begin
         bit e = 1'b1;
         for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 15) == 0) e = !e;
            cycle(e, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 9)));
         end
      end
      run_n(1, 1'b0);
      @(posedge clk);
      #4;
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
